// File: rtl/wb_arb_rr_b3.sv
// Round-robin Wishbone B3 arbiter: MASTERS requesters share one slave port, with bus-hold parking and write snoop.
// Optional stalled-slave timeout is compiled in when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_rr_b3 #(
  parameter int MASTERS = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [MASTERS*AW-1:0]   m_adr_i,
  input  logic [MASTERS*DW-1:0]   m_dat_i,
  input  logic [MASTERS*DW/8-1:0] m_sel_i,
  input  logic [MASTERS-1:0]      m_we_i,
  input  logic [MASTERS-1:0]      m_cyc_i,
  input  logic [MASTERS-1:0]      m_stb_i,
  input  logic [MASTERS*3-1:0]    m_cti_i,
  input  logic [MASTERS*2-1:0]    m_bte_i,
  output logic [MASTERS*DW-1:0]   m_dat_o,
  output logic [MASTERS-1:0]      m_ack_o,
  output logic [MASTERS-1:0]      m_err_o,
  output logic [MASTERS-1:0]      m_rty_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [DW/8-1:0]         s_sel_o,
  output logic                    s_we_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic [2:0]              s_cti_o,
  output logic [1:0]              s_bte_o,
  input  logic [DW-1:0]           s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  input  logic                    bus_hold_i,
  output logic                    bus_hold_ack_o,
  output logic [AW-1:0]           snoop_adr_o,
  output logic                    snoop_en_o,
  output logic [MASTERS-1:0]      grant_o
);

  localparam int SW = DW / 8;
  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  if (MASTERS < 2 || MASTERS > 8 || TIMEOUT < 1) begin : g_param_check
    $error("wb_arb_rr_b3: MASTERS must be 2..8 and TIMEOUT must be >= 1");
  end

  logic [1:0]         state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic               hold_ack_q, hold_ack_d;
  logic               snoop_en_q, snoop_en_d;
  logic [AW-1:0]      snoop_adr_q, snoop_adr_d;

  logic [IW-1:0]      cand;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic               granted;
  logic               tmo_hit;
  logic               tmo_abort;

  logic [AW-1:0]      adr_a [MASTERS];
  logic [DW-1:0]      dat_a [MASTERS];
  logic [SW-1:0]      sel_a [MASTERS];
  logic [2:0]         cti_a [MASTERS];
  logic [1:0]         bte_a [MASTERS];

  for (genvar n = 0; n < MASTERS; n++) begin : g_unpack
    assign adr_a[n] = m_adr_i[n*AW +: AW];
    assign dat_a[n] = m_dat_i[n*DW +: DW];
    assign sel_a[n] = m_sel_i[n*SW +: SW];
    assign cti_a[n] = m_cti_i[n*3 +: 3];
    assign bte_a[n] = m_bte_i[n*2 +: 2];
  end

  // Rotating search starting one past the last winner, wrapping at MASTERS.
  always_comb begin
    // NOTE: every combinational output gets a default up front so no path can infer a latch.
    cand     = last_q;
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < MASTERS; k++) begin
      cand = (cand == IW'(MASTERS - 1)) ? '0 : cand + 1'b1;
      if (!pick_vld && m_cyc_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    hold_ack_d = hold_ack_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_hold_i) begin
          state_d    = ST_HOLD;
          hold_ack_d = 1'b1;
        end else if (pick_vld) begin
          state_d           = ST_GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          last_d            = pick_idx;
        end
      end
      ST_GRANT: begin
        if (!m_cyc_i[last_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      ST_HOLD: begin
        if (!bus_hold_i) begin
          state_d    = ST_IDLE;
          hold_ack_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        hold_ack_d = 1'b0;
      end
    endcase
  end

  // While granted, last_q is the owner's index, so it doubles as the mux select.
  assign granted = (state_q == ST_GRANT);

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (granted) begin
      s_adr_o = adr_a[last_q];
      s_dat_o = dat_a[last_q];
      s_sel_o = sel_a[last_q];
      s_we_o  = m_we_i[last_q];
      s_cyc_o = m_cyc_i[last_q] & ~tmo_abort;
      s_stb_o = m_stb_i[last_q] & ~tmo_abort;
      s_cti_o = cti_a[last_q];
      s_bte_o = bte_a[last_q];
    end
  end

  assign m_dat_o = {MASTERS{s_dat_i}};
  assign m_ack_o = grant_q & {MASTERS{s_ack_i & ~tmo_abort}};
  assign m_err_o = grant_q & {MASTERS{(s_err_i & ~tmo_abort) | tmo_hit}};
  assign m_rty_o = grant_q & {MASTERS{s_rty_i & ~tmo_abort}};

  assign snoop_en_d  = s_cyc_o & s_stb_o & s_we_o & s_ack_i;
  assign snoop_adr_d = snoop_en_d ? s_adr_o : snoop_adr_q;

  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= IW'(MASTERS - 1);
      hold_ack_q  <= 1'b0;
      snoop_en_q  <= 1'b0;
      snoop_adr_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      hold_ack_q  <= hold_ack_d;
      snoop_en_q  <= snoop_en_d;
      snoop_adr_q <= snoop_adr_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          abort_q, abort_d;
  logic          any_resp, released, stalled;

  assign any_resp  = s_ack_i | s_err_i | s_rty_i;
  assign released  = ~granted | ~m_cyc_i[last_q];
  assign stalled   = s_stb_o & ~any_resp;
  // The hit cycle is the TIMEOUT-th stalled cycle; the abort blanks the slave port from the next one.
  assign tmo_hit   = stalled & (tmo_cnt_q == TMO_LAST);
  assign tmo_abort = abort_q;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    abort_d   = abort_q;
    if (released) begin
      tmo_cnt_d = '0;
      abort_d   = 1'b0;
    end else if (tmo_hit) begin
      tmo_cnt_d = '0;
      abort_d   = 1'b1;
    end else if (stalled) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end else if (any_resp) begin
      tmo_cnt_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_cnt_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      abort_q   <= abort_d;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign tmo_abort = 1'b0;
`endif

  assign grant_o        = grant_q;
  assign bus_hold_ack_o = hold_ack_q;
  assign snoop_en_o     = snoop_en_q;
  assign snoop_adr_o    = snoop_adr_q;

endmodule

// File: doc/wb_arb_rr_b3.md
Name: wb_arb_rr_b3

Overview:
- Round-robin Wishbone B3 arbiter. It shares one slave-side port (main RAM or the interconnect behind it) between up to MASTERS requesters, such as the ibus/dbus ports of multiple CPU cores.
- A grant is held for a whole cycle (CYC high), so B3 bursts are never split.
- It provides a bus_hold handshake for an external sequencer and a write-snoop broadcast for cache coherence.

Parameters:
- MASTERS, 4, number of requesting masters (2..8).
- AW, 32, address width.
- DW, 32, data width. Select width is DW/8.
- TIMEOUT, 255, cycles allowed with STB high and no ACK/ERR/RTY. Used only with the optional feature.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- m_adr_i  in  MASTERS*AW  master addresses, master n at bits [n*AW +: AW].
- m_dat_i  in  MASTERS*DW  master write data.
- m_sel_i  in  MASTERS*DW/8  byte selects.
- m_we_i, m_cyc_i, m_stb_i  in  MASTERS  per-master strobes.
- m_cti_i  in  MASTERS*3  cycle type identifiers.
- m_bte_i  in  MASTERS*2  burst type extensions.
- m_dat_o  out  MASTERS*DW  read data; s_dat_i is broadcast to every master.
- m_ack_o, m_err_o, m_rty_o  out  MASTERS  responses, routed to the granted master only.
- s_adr_o  out  AW  slave-side address.
- s_dat_o  out  DW  slave-side write data.
- s_sel_o  out  DW/8  slave-side byte selects.
- s_we_o, s_cyc_o, s_stb_o  out  1  slave-side strobes.
- s_cti_o  out  3  slave-side cycle type.
- s_bte_o  out  2  slave-side burst type.
- s_dat_i  in  DW  slave read data.
- s_ack_i, s_err_i, s_rty_i  in  1  slave responses.
- bus_hold_i  in  1  request to park the bus with no master granted.
- bus_hold_ack_o  out  1  bus is parked.
- snoop_adr_o  out  AW  address of the last completed write.
- snoop_en_o  out  1  one-cycle snoop strobe.
- grant_o  out  MASTERS  one-hot current grant.

Behaviour:
- Clocking and reset:
  - Single clock wb_clk_i. Reset wb_rst_i is synchronous, active-high.
  - Reset values: grant_o=0, bus_hold_ack_o=0, snoop_en_o=0, snoop_adr_o=0, all s_* strobes 0, all m_ack_o/m_err_o/m_rty_o 0.
  - Reset sets the round-robin pointer last=MASTERS-1, so master 0 wins first.
- FSM states IDLE, GRANT, HOLD. The state, grant_o and last are registered.
- IDLE:
  - If bus_hold_i=1: go to HOLD. Hold has priority over any pending m_cyc_i.
  - Else if any m_cyc_i=1: grant the first requesting master searching from last+1 upward, modulo MASTERS. Set grant_o, update last to that index, go to GRANT.
  - Arbitration latency: 1 cycle from CYC to grant. The master sees s_* driven the cycle after it raises CYC.
- GRANT:
  - s_adr/dat/sel/we/cyc/stb/cti/bte are a combinational mux of the granted master's inputs.
  - m_ack/err/rty for the granted index equal s_ack/err/rty; all other indices are 0.
  - When the granted master's m_cyc_i falls: grant_o is cleared and the state returns to IDLE.
  - One dead cycle exists between consecutive grants.
  - Bursts (cti 001/010 through 111) stay within one grant because the grant releases only on CYC low.
- HOLD:
  - No grant; all s_* strobes 0; bus_hold_ack_o=1, registered.
  - Exit to IDLE when bus_hold_i=0; bus_hold_ack_o falls on the same edge.
  - bus_hold_i raised during GRANT waits until the grant is released.
- Snoop:
  - Trigger: on any cycle with s_cyc_o & s_stb_o & s_we_o & s_ack_i.
  - Next cycle: snoop_en_o=1 and snoop_adr_o=s_adr_o. snoop_adr_o holds until the next write.
  - Back-to-back burst write acks give consecutive snoop_en_o pulses, each with its own address.
  - ERR/RTY on a write produce no snoop.
- Boundary conditions:
  - Slave responses while no grant is active are ignored; no master sees them.
  - With one requester continuously active, that requester re-wins after each release. The dead cycle is still inserted.
  - All masters requesting: grants rotate 0,1,2,...,MASTERS-1,0.
  - Reset mid-burst: s_cyc_o drops on the reset edge; no ACK is forwarded afterwards.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter (width clog2(TIMEOUT+1)) increments each GRANT cycle with s_stb_o=1 and no s_ack_i/s_err_i/s_rty_i. It clears on any response or release.
  - When it reaches TIMEOUT: the granted master gets m_err_o=1 for one cycle, and s_cyc_o/s_stb_o are forced 0 until the master drops CYC. The FSM then returns to IDLE normally.
- Undefined: no counter; a stalled slave holds the grant indefinitely.

Test Plan:
- Reset, then m_cyc_i=4'b0101 simultaneously -> grant_o=0001 one cycle later; after master 0 drops CYC plus 1 dead cycle -> grant_o=0100.
- Master 1 runs a 4-beat incrementing burst (cti 010,010,010,111) while master 0 requests -> all 4 acks reach master 1 only; master 0 is granted only after master 1 drops CYC.
- All 4 masters request continuously, each doing single transfers -> grant order 0,1,2,3,0, each master serviced exactly once per round.
- Master 2 writes to address 0x00001000 and is acked -> snoop_en_o=1 for exactly one cycle next cycle, snoop_adr_o=0x00001000. A read to the same address produces no pulse.
- bus_hold_i=1 during master 3's transfer -> bus_hold_ack_o=1 only after master 3 releases; a new m_cyc_i from master 0 is not granted until bus_hold_i=0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT=8, the slave never acks -> m_err_o[granted]=1 on the 8th stalled cycle, and s_cyc_o=0 from the next cycle.
